// File: rtl/pll_reset_seq.sv
// Sequences the design reset from PLL lock: synchronize, qualify, settle, release in the PLL clock domain.
// Define PLL_RESET_LOSSCOUNT_EN to add the 8-bit saturating loss_count register and port.
module pll_reset_seq #(
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       lock_in,
   output logic       rst_out,
   output logic       ready,
   output logic [2:0] state_out
`ifdef PLL_RESET_LOSSCOUNT_EN
   ,
   output logic [7:0] loss_count
`endif
);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      QUALIFY   = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      LOST      = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync1_d;
   logic             lock_s_q, lock_s_d;
   logic             rst_out_q, rst_out_d;
   logic             ready_q, ready_d;
`ifdef PLL_RESET_LOSSCOUNT_EN
   logic [7:0]       loss_q, loss_d;
`endif

   // Next state; loss of lock wins over a counter reaching its terminal value.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sync1_d  = lock_in;
      lock_s_d = sync1_q;
      case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (lock_s_q) state_d = QUALIFY;
         end
         QUALIFY: begin
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SETTLE: begin
            if (!lock_s_q) begin
               state_d = LOST;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            cnt_d = '0;
            if (!lock_s_q) state_d = LOST;
         end
         LOST: begin
            cnt_d   = '0;
            state_d = WAIT_LOCK;
         end
         default: begin
            cnt_d   = '0;
            state_d = WAIT_LOCK;
         end
      endcase

      rst_out_d = (state_d != RUN);
      ready_d   = (state_d == RUN);

`ifdef PLL_RESET_LOSSCOUNT_EN
      loss_d = loss_q;
      if ((state_d == LOST) && (state_q != LOST) && (loss_q != 8'hFF))
         loss_d = loss_q + 8'd1;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= WAIT_LOCK;
         cnt_q     <= '0;
         sync1_q   <= 1'b0;
         lock_s_q  <= 1'b0;
         rst_out_q <= 1'b1;
         ready_q   <= 1'b0;
`ifdef PLL_RESET_LOSSCOUNT_EN
         loss_q    <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sync1_q   <= sync1_d;
         lock_s_q  <= lock_s_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
`ifdef PLL_RESET_LOSSCOUNT_EN
         loss_q    <= loss_d;
`endif
      end
   end

   assign rst_out   = rst_out_q;
   assign ready     = ready_q;
   assign state_out = state_q;
`ifdef PLL_RESET_LOSSCOUNT_EN
   assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq: progress-count reference model checked every cycle, plus directed latency checks.
module tb_pll_reset_seq;

   localparam int unsigned LOCK = 8;
   localparam int unsigned HOLD = 4;

   logic       clock   = 1'b0;
   logic       reset   = 1'b1;
   logic       lock_in = 1'b0;
   logic       rst_out;
   logic       ready;
   logic [2:0] state_out;
`ifdef PLL_RESET_LOSSCOUNT_EN
   logic [7:0] loss_count;
`endif

   int checks = 0;
   int errors = 0;

   pll_reset_seq #(
      .LOCK_CYCLES(LOCK),
      .HOLD_CYCLES(HOLD),
      .CNT_W      (16)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .lock_in  (lock_in),
      .rst_out  (rst_out),
      .ready    (ready),
      .state_out(state_out)
`ifdef PLL_RESET_LOSSCOUNT_EN
      ,
      .loss_count(loss_count)
`endif
   );

   always #5 clock = ~clock;

   // Model: lock_s is lock_in two edges late; m_p counts edges of uninterrupted progress since leaving WAIT.
   bit m_l1, m_ls, m_active, m_lost;
   int m_p, m_loss;

   function automatic int m_state();
      if (m_lost)                 return 4;
      if (!m_active)              return 0;
      if (m_p < int'(LOCK))       return 1;
      if (m_p < int'(LOCK + HOLD)) return 2;
      return 3;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_l1 <= 1'b0; m_ls <= 1'b0; m_active <= 1'b0; m_lost <= 1'b0;
         m_p <= 0; m_loss <= 0;
      end else begin
         m_ls <= m_l1;
         m_l1 <= lock_in;
         if (m_lost) begin
            m_lost <= 1'b0;
         end else if (!m_active) begin
            if (m_ls) begin
               m_active <= 1'b1;
               m_p      <= 0;
            end
         end else if (!m_ls) begin
            m_active <= 1'b0;
            if (m_p >= int'(LOCK)) begin
               m_lost <= 1'b1;
               if (m_loss < 255) m_loss <= m_loss + 1;
            end
         end else if (m_p < int'(LOCK + HOLD)) begin
            m_p <= m_p + 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      chk("state_out", int'(state_out), m_state());
      chk("rst_out", int'(rst_out), (m_state() != 3) ? 1 : 0);
      chk("ready", int'(ready), (m_state() == 3) ? 1 : 0);
`ifdef PLL_RESET_LOSSCOUNT_EN
      chk("loss_count", int'(loss_count), m_loss);
`endif
   end

   // Counts negedges until ready equals val; n-th negedge follows the n-th edge after the call.
   task automatic wait_ready(input logic val, input int max_cyc, output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (ready !== val && n < max_cyc);
      if (ready !== val) begin
         checks++; errors++;
         $display("FAIL wait_ready timeout actual %0b required %0b", ready, val);
      end
   endtask

   task automatic wait_state(input int val, input int max_cyc);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (int'(state_out) != val && n < max_cyc);
      if (int'(state_out) != val) begin
         checks++; errors++;
         $display("FAIL wait_state timeout actual %0d required %0d", state_out, val);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clock);
      chk("reset_rst_out", int'(rst_out), 1);
      chk("reset_ready", int'(ready), 0);
      chk("reset_state", int'(state_out), 0);

      // Constant lock from the first edge after release.
      reset   = 1'b0;
      lock_in = 1'b1;
      wait_ready(1'b1, 60, n);
      chk("lock_to_run_latency", n, 15);
      chk("run_rst_out", int'(rst_out), 0);

      // Lock drop in RUN.
      repeat (3) @(negedge clock);
      lock_in = 1'b0;
      wait_ready(1'b0, 10, n);
      chk("drop_latency", n, 3);
      chk("drop_state_lost", int'(state_out), 4);
      chk("drop_rst_out", int'(rst_out), 1);
`ifdef PLL_RESET_LOSSCOUNT_EN
      chk("drop_loss_count", int'(loss_count), 1);
`endif
      @(negedge clock);
      chk("after_lost_state", int'(state_out), 0);

      // Glitch: 5 high, 1 low, then high; qualify restarts from the re-rise.
      repeat (4) @(negedge clock);
      lock_in = 1'b1;
      repeat (5) @(negedge clock);
      lock_in = 1'b0;
      @(negedge clock);
      lock_in = 1'b1;
      wait_ready(1'b1, 60, n);
      chk("glitch_latency", n, 15);

      // Drop during SETTLE goes to LOST, never RUN.
      lock_in = 1'b0;
      repeat (6) @(negedge clock);
      lock_in = 1'b1;
      wait_state(2, 40);
      lock_in = 1'b0;
      repeat (3) @(negedge clock);
      chk("settle_drop_state", int'(state_out), 4);
      chk("settle_drop_rst_out", int'(rst_out), 1);

      // Async reset pulse mid-SETTLE, away from the clock edges.
      repeat (4) @(negedge clock);
      lock_in = 1'b1;
      wait_state(2, 40);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_out", int'(rst_out), 1);
      chk("async_state", int'(state_out), 0);
      chk("async_ready", int'(ready), 0);
`ifdef PLL_RESET_LOSSCOUNT_EN
      chk("async_loss_count", int'(loss_count), 0);
`endif
      @(negedge clock);
      #3 reset = 1'b0;
      wait_ready(1'b1, 60, n);
      chk("post_reset_latency", n, 15);

      // Random lock bursts with occasional unaligned reset pulses.
      for (int i = 0; i < 150; i++) begin
         lock_in = 1'b1;
         repeat ($urandom_range(1, 30)) @(negedge clock);
         lock_in = 1'b0;
         repeat ($urandom_range(1, 6)) @(negedge clock);
         if ($urandom_range(0, 19) == 0) begin
            #1 reset = 1'b1;
            #($urandom_range(1, 3) + ($urandom_range(0, 1) == 1 ? 4 : 0));
            reset = 1'b0;
         end
      end

`ifdef PLL_RESET_LOSSCOUNT_EN
      // 300 full lock/loss cycles saturate the loss counter.
      lock_in = 1'b0;
      repeat (6) @(negedge clock);
      for (int i = 0; i < 300; i++) begin
         lock_in = 1'b1;
         repeat (16) @(negedge clock);
         lock_in = 1'b0;
         repeat (4) @(negedge clock);
      end
      chk("loss_saturated", int'(loss_count), 255);
`endif

      repeat (5) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
